// File: rtl/arbitro_transferencia.sv
// Round-robin arbiter granting two CPUs access to a shared transfer area,
// with a 2-flop synchronized four-phase handshake to the peripheral.
module arbitro_transferencia #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [1:0]    dado0,
    input  logic [1:0]    dado1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [1:0]    send,
    output logic [1:0]    dadoT,
    input  logic [1:0]    ack,
    output logic          erro,
    output logic [CW-1:0] cnt_transf
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ENVIA  = 3'd1;
    localparam logic [2:0] LIBERA = 3'd2;
    localparam logic [2:0] FIM    = 3'd3;
    localparam logic [2:0] ERRO   = 3'd4;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [2:0]    next_state;
    logic [1:0]    ack_m;
    logic [1:0]    ack_s;
    logic [TW-1:0] tmr;
    logic          owner;
    logic          prio;
    logic          ativo;
    logic          winner;
    logic          ack_bad;
    logic          own;

    assign ack_bad = ack_s[1];
    assign winner  = (req0 && req1) ? prio : req1;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                // ativo holds off arbitration for one edge after reset release
                if (ativo && (req0 || req1))
                    next_state = ENVIA;
            end
            ENVIA: begin
                if (ack_bad)
                    next_state = ERRO;
                else if (ack_s == 2'b01)
                    next_state = LIBERA;
                else if (tmr == TMAX)
                    next_state = ERRO;
            end
            LIBERA: begin
                if (ack_bad)
                    next_state = ERRO;
                else if (ack_s == 2'b00)
                    next_state = FIM;
                else if (tmr == TMAX)
                    next_state = ERRO;
            end
            FIM:     next_state = IDLE;
            ERRO:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ack_m      <= 2'b00;
            ack_s      <= 2'b00;
            tmr        <= '0;
            owner      <= 1'b0;
            prio       <= 1'b0;
            ativo      <= 1'b0;
            dadoT      <= 2'b00;
            cnt_transf <= '0;
        end else begin
            ack_m <= ack;
            ack_s <= ack_m;
            ativo <= 1'b1;
            state <= next_state;
            if (state == IDLE && next_state == ENVIA) begin
                owner <= winner;
                dadoT <= winner ? dado1 : dado0;
            end
            if (next_state != state)
                tmr <= '0;
            else if (state == ENVIA || state == LIBERA)
                tmr <= tmr + 1'b1;
            if (state == LIBERA && next_state == FIM)
                cnt_transf <= cnt_transf + CW'(1);
            if (next_state == FIM || next_state == ERRO)
                prio <= ~owner;
        end
    end

    // Outputs decode from state so an async reset drops them at once
    assign own   = (state == ENVIA) || (state == LIBERA) || (state == FIM);
    assign gnt0  = own && !owner;
    assign gnt1  = own && owner;
    assign send  = {1'b0, state == ENVIA};
    assign done0 = (state == FIM) && !owner;
    assign done1 = (state == FIM) && owner;
    assign erro  = (state == ERRO);

endmodule
